// File: rtl/pixel_seq_pkg.sv
// pixel_seq_pkg: shared state encoding, code type and
// default phase lengths for the pixel array sequencer.
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_RD_SETTLE,
    ST_RD_CAPTURE,
    ST_STREAM
  } seq_state_t;

  typedef logic [7:0]  pix_code_t;
  typedef logic [15:0] phase_cnt_t;

  localparam int DEF_H_PIXELS      = 4;
  localparam int DEF_V_PIXELS      = 4;
  localparam int DEF_ERASE_CYCLES  = 5;
  localparam int DEF_EXPOSE_CYCLES = 255;
  localparam int DEF_COUNT_MAX     = 255;

endpackage

// File: rtl/pixel_ramp_counter.sv
// pixel_ramp_counter: 8-bit conversion ramp, 0..count_max
// while converting, held at 0 otherwise; never wraps.
module pixel_ramp_counter
  import pixel_seq_pkg::*;
#(
  parameter int count_max = DEF_COUNT_MAX
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      active,
  input  logic      stay,
  output pix_code_t count,
  output logic      done
);

  localparam pix_code_t last_code = pix_code_t'(count_max);

  // Step while the FSM remains in conversion, else clear to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!(active && stay)) begin
      count <= '0;
    end else if (count != last_code) begin
      count <= count + 8'd1;
    end
  end

  assign done = active && (count == last_code);

endmodule

// File: rtl/pixel_sequencer.sv
// pixel_sequencer: erase/expose/convert/read sequencing for
// the pixel array with a valid/ready pixel stream out.
module pixel_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int horizontal_pixels = DEF_H_PIXELS,
  parameter int vertical_pixels   = DEF_V_PIXELS,
  parameter int erase_cycles      = DEF_ERASE_CYCLES,
  parameter int expose_cycles     = DEF_EXPOSE_CYCLES,
  parameter int count_max         = DEF_COUNT_MAX,
  localparam int col_w =
    (horizontal_pixels > 1) ? $clog2(horizontal_pixels) : 1,
  localparam int row_w =
    (vertical_pixels > 1) ? $clog2(vertical_pixels) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             erase,
  output logic                             expose,
  output logic                             convert,
  output logic [vertical_pixels-1:0]       read,
  output pix_code_t [0:horizontal_pixels-1] pix_drv,
  output logic                             pix_oe,
  input  pix_code_t [0:horizontal_pixels-1] pix_in,
  output logic                             m_valid,
  input  logic                             m_ready,
  output pix_code_t                        m_data,
  output logic [row_w-1:0]                 m_row,
  output logic [col_w-1:0]                 m_col,
  output logic                             m_last,
  output logic                             busy
);

  localparam logic [row_w-1:0] last_row =
    row_w'(vertical_pixels - 1);
  localparam logic [col_w-1:0] last_col =
    col_w'(horizontal_pixels - 1);
  localparam logic [vertical_pixels-1:0] row_one =
    vertical_pixels'(1);

  seq_state_t state, state_n;
  phase_cnt_t timer, timer_n;
  logic [row_w-1:0] row, row_n;
  logic [col_w-1:0] col, col_n;
  pix_code_t [0:horizontal_pixels-1] row_buf, row_buf_n;
  pix_code_t ramp;
  logic      ramp_done;
  logic      hs;
  logic      rd_n;
  logic      strm_n;

  assign hs     = m_valid && m_ready;
  assign rd_n   = (state_n == ST_RD_SETTLE) ||
                  (state_n == ST_RD_CAPTURE);
  assign strm_n = (state_n == ST_STREAM);

  pixel_ramp_counter #(
    .count_max(count_max)
  ) u_ramp (
    .clk   (clk),
    .reset (reset),
    .active(state == ST_CONVERT),
    .stay  (state_n == ST_CONVERT),
    .count (ramp),
    .done  (ramp_done)
  );

  assign pix_drv = {horizontal_pixels{ramp}};

  // Next-state, phase timer, row/column and row capture.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    row_n     = row;
    col_n     = col;
    row_buf_n = row_buf;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_ERASE;
          timer_n = phase_cnt_t'(erase_cycles - 1);
        end
      end
      ST_ERASE: begin
        timer_n = timer - 1'b1;
        if (timer == '0) begin
          state_n = ST_EXPOSE;
          timer_n = phase_cnt_t'(expose_cycles - 1);
        end
      end
      ST_EXPOSE: begin
        timer_n = timer - 1'b1;
        if (timer == '0) state_n = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (ramp_done) begin
          state_n = ST_RD_SETTLE;
          row_n   = '0;
        end
      end
      ST_RD_SETTLE: state_n = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        state_n   = ST_STREAM;
        col_n     = '0;
        row_buf_n = pix_in;
      end
      ST_STREAM: begin
        if (hs) begin
          if (col != last_col) begin
            col_n = col + 1'b1;
          end else if (row != last_row) begin
            row_n   = row + 1'b1;
            state_n = ST_RD_SETTLE;
          end else if (start) begin
            state_n = ST_ERASE;
            timer_n = phase_cnt_t'(erase_cycles - 1);
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register and outputs registered from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      timer   <= '0;
      row     <= '0;
      col     <= '0;
      row_buf <= '0;
      busy    <= 1'b0;
      erase   <= 1'b0;
      expose  <= 1'b0;
      convert <= 1'b0;
      pix_oe  <= 1'b0;
      read    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_row   <= '0;
      m_col   <= '0;
      m_last  <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      row     <= row_n;
      col     <= col_n;
      row_buf <= row_buf_n;
      busy    <= state_n != ST_IDLE;
      erase   <= state_n == ST_ERASE;
      expose  <= state_n == ST_EXPOSE;
      convert <= state_n == ST_CONVERT;
      pix_oe  <= state_n == ST_CONVERT;
      read    <= rd_n ? (row_one << row_n) : '0;
      m_valid <= strm_n;
      m_data  <= strm_n ? row_buf_n[col_n] : '0;
      m_row   <= strm_n ? row_n : '0;
      m_col   <= strm_n ? col_n : '0;
      m_last  <= strm_n && (row_n == last_row) &&
                 (col_n == last_col);
    end
  end

endmodule
